// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, issues instruction SRAM reads and forwards {ce, pc} to ID.
// A redirect that arrives while IF is stalled is parked and applied when the stall lifts.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] fetch_count
);

  localparam logic STOP = 1'b1;

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_reg, pend_addr, next_pc;
  logic        ce_reg, pend_valid, frozen;
  logic        br_e;
  logic [31:0] br_addr;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign frozen  = (stall[0] == STOP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:     state_nxt = RUN;
      RUN,
      PEND: begin
        if (!frozen)   state_nxt = RUN;
        else if (br_e) state_nxt = PEND;
      end
      default:  state_nxt = BOOT;
    endcase
  end

  // Output / decode logic
  always_comb begin
    ce_reg     = (state != BOOT);
    pend_valid = (state == PEND);
    // Redirects are ignored while booting; the first fetch is always RESET_PC+4
    if (ce_reg && br_e)   next_pc = br_addr;
    else if (pend_valid)  next_pc = pend_addr;
    else                  next_pc = pc_reg + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      pend_addr   <= 32'd0;
      fetch_count <= 32'd0;
    end else if (!ce_reg) begin
      pc_reg <= next_pc;
    end else if (!frozen) begin
      pc_reg      <= next_pc;
      fetch_count <= fetch_count + 32'd1;
    end else if (br_e) begin
      pend_addr <= br_addr;
    end
  end

  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_en    = ce_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: boot sequence, redirects, stalled redirects, reset, PC wrap.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Checks pc, ce and fetch count together after a clock edge
  task automatic chk_state(input string tag, input logic [31:0] pc, input logic ce,
                           input logic [31:0] fc);
    chk({tag, ".pc"}, {32'd0, inst_sram_addr}, {32'd0, pc});
    chk({tag, ".bus"}, {31'd0, if_to_id_bus}, {31'd0, ce, pc});
    chk({tag, ".en"}, {63'd0, inst_sram_en}, {63'd0, ce});
    chk({tag, ".fc"}, {32'd0, fetch_count}, {32'd0, fc});
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; br_bus = 33'd0;
    // 1: reset and boot
    step; step; step;
    chk_state("rst", 32'hBFBF_FFFC, 1'b0, 32'd0);
    chk("wen", {60'd0, inst_sram_wen}, 64'd0);
    chk("wdata", {32'd0, inst_sram_wdata}, 64'd0);
    rst = 1'b0;
    step; chk_state("boot", 32'hBFC0_0000, 1'b1, 32'd0);
    step; chk_state("run1", 32'hBFC0_0004, 1'b1, 32'd1);
    step; chk_state("run2", 32'hBFC0_0008, 1'b1, 32'd2);
    step; chk_state("run3", 32'hBFC0_000C, 1'b1, 32'd3);
    step; chk_state("run4", 32'hBFC0_0010, 1'b1, 32'd4);
    // 2: live redirect
    br_bus = {1'b1, 32'hBFC0_0100};
    step; chk_state("br", 32'hBFC0_0100, 1'b1, 32'd5);
    br_bus = 33'd0;
    step; chk_state("br+4", 32'hBFC0_0104, 1'b1, 32'd6);
    // 3: redirect during a 3-cycle stall
    br_bus = {1'b1, 32'hBFC0_0020};
    step; chk_state("to20", 32'hBFC0_0020, 1'b1, 32'd7);
    br_bus = 33'd0; stall = 6'b000001;
    step; chk_state("st1", 32'hBFC0_0020, 1'b1, 32'd7);
    br_bus = {1'b1, 32'hBFC0_0200};
    step; chk_state("st2", 32'hBFC0_0020, 1'b1, 32'd7);
    br_bus = 33'd0;
    step; chk_state("st3", 32'hBFC0_0020, 1'b1, 32'd7);
    stall = 6'd0;
    step; chk_state("pend", 32'hBFC0_0200, 1'b1, 32'd8);
    step; chk_state("pendclr", 32'hBFC0_0204, 1'b1, 32'd9);
    // 4: two stalled redirects, latest wins; upper stall bits ignored
    stall = 6'b111111; br_bus = {1'b1, 32'hBFC0_0300};
    step; br_bus = {1'b1, 32'hBFC0_0400};
    step; br_bus = 33'd0;
    step; chk_state("st2x", 32'hBFC0_0204, 1'b1, 32'd9);
    stall = 6'b111110;
    step; chk_state("latest", 32'hBFC0_0400, 1'b1, 32'd10);
    step; chk_state("latest+4", 32'hBFC0_0404, 1'b1, 32'd11);
    // 5: live redirect overrides pending one
    stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0500};
    step; br_bus = 33'd0;
    step; stall = 6'd0; br_bus = {1'b1, 32'hBFC0_0600};
    step; chk_state("override", 32'hBFC0_0600, 1'b1, 32'd12);
    br_bus = 33'd0;
    step; chk_state("override+4", 32'hBFC0_0604, 1'b1, 32'd13);
    // 6: reset in PEND discards target; boot ignores stall and br
    stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0700};
    step; br_bus = 33'd0; rst = 1'b1; stall = 6'd0;
    step; chk_state("rst2", 32'hBFBF_FFFC, 1'b0, 32'd0);
    rst = 1'b0; stall = 6'b000001; br_bus = {1'b1, 32'h1234_5678};
    step; chk_state("boot2", 32'hBFC0_0000, 1'b1, 32'd0);
    stall = 6'd0; br_bus = 33'd0;
    step; chk_state("nopend", 32'hBFC0_0004, 1'b1, 32'd1);
    // PC wrap
    br_bus = {1'b1, 32'hFFFF_FFFC};
    step; chk_state("top", 32'hFFFF_FFFC, 1'b1, 32'd2);
    br_bus = 33'd0;
    step; chk_state("wrap", 32'h0000_0000, 1'b1, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
